// File: rtl/key_debounce_multi_if.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce_multi_if
// Brief   : Key pin and conditioned-event bundle for key_debounce_multi.
// Revision: 1.0 - initial release
// ============================================================================
interface key_debounce_multi_if #(
  parameter int N_KEYS = 4
) ();
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;

  modport master (
    output key_in,
    input  key_level, press_pulse, release_pulse, long_pulse
  );

  modport slave (
    input  key_in,
    output key_level, press_pulse, release_pulse, long_pulse
  );
endinterface
`default_nettype wire

// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce_multi
// Brief   : N-channel key conditioner: sync, symmetric debounce, level and
//           press/release/long-press pulses per channel.
// Revision: 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input wire logic            clk,
  input wire logic            rst_n,
  key_debounce_multi_if.slave bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(LONG_CYC);

  localparam logic [DB_W-1:0]   c_DEB_MAX   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] c_HOLD_MAX  = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] c_LONG_FIRE = HOLD_W'(LONG_CYC - 2);
  localparam logic              c_RELEASED  = ACTIVE_LOW;

  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;
  logic [N_KEYS-1:0] w_long;

  generate
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      logic              r_sync1;
      logic              r_sync2;
      logic              r_level;
      logic              r_press;
      logic              r_release;
      logic              r_long;
      logic [DB_W-1:0]   r_cnt;
      logic [HOLD_W-1:0] r_hold;
      logic              w_p;
      logic              w_mismatch;
      logic              w_toggle;

      assign w_p        = r_sync2 ^ ACTIVE_LOW;
      assign w_mismatch = (w_p != r_level);
      assign w_toggle   = w_mismatch && (r_cnt == c_DEB_MAX);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_sync1   <= c_RELEASED;
          r_sync2   <= c_RELEASED;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          r_long    <= 1'b0;
          r_cnt     <= '0;
          r_hold    <= '0;
        end else begin
          r_sync1   <= bus.key_in[i];
          r_sync2   <= r_sync1;
          r_press   <= w_toggle && !r_level;
          r_release <= w_toggle && r_level;

          if (w_toggle) begin
            r_level <= !r_level;
            r_cnt   <= '0;
          end else if (w_mismatch) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
          end

          if (!r_level) begin
            r_hold <= '0;
          end else if (r_hold != c_HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
          end

          // A release accepted on the very edge the hold matures must not also report a long press.
          r_long <= r_level && !w_toggle && (r_hold == c_LONG_FIRE);
        end
      end

      assign w_level[i]   = r_level;
      assign w_press[i]   = r_press;
      assign w_release[i] = r_release;
      assign w_long[i]    = r_long;
    end
  endgenerate

  assign bus.key_level     = w_level;
  assign bus.press_pulse   = w_press;
  assign bus.release_pulse = w_release;
  assign bus.long_pulse    = w_long;

endmodule
`default_nettype wire
